// File: rtl/uart_command_processor.sv
// uart_command_processor
//
// Purpose:
//   Serial command front end for an 8-bit register file and a 16-bit ALU.
//   Bytes received on RX_IN drive a command FSM that can write registers,
//   read registers, or run an ALU operation. Results are queued and sent
//   back on TX_OUT. Register 2 holds the parity configuration shared by RX
//   and TX (bit0 = parity enable, bit1 = odd parity).
//
// Ports:
//   REF_CLK  in   system clock, rising edge
//   RST      in   asynchronous active-low reset
//   RX_IN    in   serial receive line, idle high
//   TX_OUT   out  serial transmit line, idle high
//
// Frame format (both directions): start(0), 8 data bits LSB first,
// optional parity, stop(1).

module uart_command_processor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int RF_DEPTH     = 16,
    parameter int TXQ_DEPTH    = 4
) (
    input  logic REF_CLK,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT
);

    localparam int AW   = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int QW   = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
    localparam int QCW  = $clog2(TXQ_DEPTH + 1);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [3:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B,
                              ALU_FUN, ALU_LO, ALU_HI} cmd_state_t;

    logic [7:0] regs [RF_DEPTH];
    logic       cfg_par_en;
    logic       cfg_par_odd;

    assign cfg_par_en  = regs[2][0];
    assign cfg_par_odd = regs[2][1];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [2:0]      rx_bit, rx_bit_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            rx_par_en, rx_par_en_nxt;
    logic            rx_par_odd, rx_par_odd_nxt;
    logic            rx_err, rx_err_nxt;
    logic            rx_valid;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shift   <= rx_shift_nxt;
            rx_par_en  <= rx_par_en_nxt;
            rx_par_odd <= rx_par_odd_nxt;
            rx_err     <= rx_err_nxt;
        end
    end

    // Parity config is captured at the start edge so a reg2 write only
    // affects frames that begin afterwards. rx_valid pulses at mid stop bit.
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt + CW'(1);
        rx_bit_nxt     = rx_bit;
        rx_shift_nxt   = rx_shift;
        rx_par_en_nxt  = rx_par_en;
        rx_par_odd_nxt = rx_par_odd;
        rx_err_nxt     = rx_err;
        rx_valid       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_nxt   = RX_START;
                    rx_par_en_nxt  = cfg_par_en;
                    rx_par_odd_nxt = cfg_par_odd;
                    rx_err_nxt     = 1'b0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = rx_par_en ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_err_nxt   = rx_sync != (rx_par_odd ? ~^rx_shift : ^rx_shift);
                    rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    rx_valid     = rx_sync && !rx_err;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // TX queue
    // ------------------------------------------------------------------
    logic [7:0]     q_mem [TXQ_DEPTH];
    logic [QW-1:0]  q_wr, q_rd;
    logic [QCW-1:0] q_count;
    logic           q_empty, q_full;
    logic           push_en, do_push, pop;
    logic [7:0]     push_data;

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == QCW'(TXQ_DEPTH));
    assign do_push = push_en && !q_full;

    always_ff @(posedge REF_CLK) begin
        if (do_push) begin
            q_mem[q_wr] <= push_data;
        end
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else begin
            if (do_push) begin
                q_wr <= (q_wr == QW'(TXQ_DEPTH - 1)) ? '0 : q_wr + QW'(1);
            end
            if (pop) begin
                q_rd <= (q_rd == QW'(TXQ_DEPTH - 1)) ? '0 : q_rd + QW'(1);
            end
            case ({do_push, pop})
                2'b10:   q_count <= q_count + QCW'(1);
                2'b01:   q_count <= q_count - QCW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_par_en, tx_par_en_nxt;
    logic          tx_par, tx_par_nxt;
    logic          tx_line, tx_line_nxt;

    assign TX_OUT = tx_line;

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par_en <= 1'b0;
            tx_par    <= 1'b0;
            tx_line   <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_par_en <= tx_par_en_nxt;
            tx_par    <= tx_par_nxt;
            tx_line   <= tx_line_nxt;
        end
    end

    // The line level is derived from the next state so TX_OUT comes
    // straight from a flop and each bit lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt + CW'(1);
        tx_bit_nxt    = tx_bit;
        tx_shift_nxt  = tx_shift;
        tx_par_en_nxt = tx_par_en;
        tx_par_nxt    = tx_par;
        pop           = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                if (!q_empty) begin
                    pop           = 1'b1;
                    tx_state_nxt  = TX_START;
                    tx_shift_nxt  = q_mem[q_rd];
                    tx_par_en_nxt = cfg_par_en;
                    tx_par_nxt    = cfg_par_odd ? ~^q_mem[q_rd] : ^q_mem[q_rd];
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    tx_bit_nxt = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START:  tx_line_nxt = 1'b0;
            TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
            TX_PARITY: tx_line_nxt = tx_par_nxt;
            default:   tx_line_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: operands are always reg0/reg1, function comes from the
    // received byte; the result is registered when the function byte lands.
    // ------------------------------------------------------------------
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_res, alu_q;

    assign alu_a   = regs[0];
    assign alu_b   = regs[1];
    assign alu_fun = rx_shift[3:0];

    always_comb begin
        alu_res = '0;
        case (alu_fun)
            4'd0:    alu_res = {8'h00, alu_a} + {8'h00, alu_b};
            4'd1:    alu_res = {8'h00, alu_a} - {8'h00, alu_b};
            4'd2:    alu_res = {8'h00, alu_a} * {8'h00, alu_b};
            4'd3:    alu_res = (alu_b == 8'h00) ? 16'h0000 : {8'h00, alu_a / alu_b};
            4'd4:    alu_res = {8'h00, alu_a & alu_b};
            4'd5:    alu_res = {8'h00, alu_a | alu_b};
            4'd6:    alu_res = {8'h00, ~(alu_a & alu_b)};
            4'd7:    alu_res = {8'h00, ~(alu_a | alu_b)};
            4'd8:    alu_res = {8'h00, alu_a ^ alu_b};
            4'd9:    alu_res = {8'h00, ~(alu_a ^ alu_b)};
            4'd10:   alu_res = (alu_a == alu_b) ? 16'd1 : 16'd0;
            4'd11:   alu_res = (alu_a > alu_b) ? 16'd2 : 16'd0;
            4'd12:   alu_res = (alu_a < alu_b) ? 16'd3 : 16'd0;
            4'd13:   alu_res = {9'h000, alu_a[7:1]};
            4'd14:   alu_res = {7'h00, alu_a, 1'b0};
            default: alu_res = {9'h000, alu_b[7:1]};
        endcase
    end

    // ------------------------------------------------------------------
    // Command FSM and register file
    // ------------------------------------------------------------------
    cmd_state_t     cmd_state, cmd_state_nxt;
    logic [AW-1:0]  addr_q;
    logic           addr_load, alu_load, rf_we;
    logic [AW-1:0]  rf_waddr;

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            cmd_state <= IDLE;
            addr_q    <= '0;
            alu_q     <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= (i == 2) ? 8'h01 : 8'h00;
            end
        end else begin
            cmd_state <= cmd_state_nxt;
            if (addr_load) addr_q <= rx_shift[AW-1:0];
            if (alu_load)  alu_q  <= alu_res;
            if (rf_we)     regs[rf_waddr] <= rx_shift;
        end
    end

    // Advances one step per valid byte; the two ALU push states follow the
    // function byte on consecutive cycles, well before the next byte.
    always_comb begin
        cmd_state_nxt = cmd_state;
        addr_load     = 1'b0;
        alu_load      = 1'b0;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        push_en       = 1'b0;
        push_data     = alu_q[7:0];
        case (cmd_state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_shift)
                        8'hAA:   cmd_state_nxt = WR_ADDR;
                        8'hBB:   cmd_state_nxt = RD_ADDR;
                        8'hCC:   cmd_state_nxt = ALU_A;
                        8'hDD:   cmd_state_nxt = ALU_FUN;
                        default: cmd_state_nxt = IDLE;
                    endcase
                end
            end
            WR_ADDR: if (rx_valid) begin
                addr_load     = 1'b1;
                cmd_state_nxt = WR_DATA;
            end
            WR_DATA: if (rx_valid) begin
                rf_we         = 1'b1;
                rf_waddr      = addr_q;
                cmd_state_nxt = IDLE;
            end
            RD_ADDR: if (rx_valid) begin
                push_en       = 1'b1;
                push_data     = regs[rx_shift[AW-1:0]];
                cmd_state_nxt = IDLE;
            end
            ALU_A: if (rx_valid) begin
                rf_we         = 1'b1;
                rf_waddr      = AW'(0);
                cmd_state_nxt = ALU_B;
            end
            ALU_B: if (rx_valid) begin
                rf_we         = 1'b1;
                rf_waddr      = AW'(1);
                cmd_state_nxt = ALU_FUN;
            end
            ALU_FUN: if (rx_valid) begin
                alu_load      = 1'b1;
                cmd_state_nxt = ALU_LO;
            end
            ALU_LO: begin
                push_en       = 1'b1;
                push_data     = alu_q[7:0];
                cmd_state_nxt = ALU_HI;
            end
            ALU_HI: begin
                push_en       = 1'b1;
                push_data     = alu_q[15:8];
                cmd_state_nxt = IDLE;
            end
            default: cmd_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_command_processor.sv
// tb_uart_command_processor
//
// Drives serial command frames into uart_command_processor and decodes the
// frames it sends back. Expected reply bytes, together with the parity
// setting they should be sent with, are queued when a command is driven and
// compared as each reply frame is decoded.

module tb_uart_command_processor;

    localparam int CPB = 16;

    logic REF_CLK = 1'b0;
    logic RST;
    logic RX_IN;
    logic TX_OUT;

    always #5 REF_CLK = ~REF_CLK;

    uart_command_processor #(
        .CLKS_PER_BIT (CPB),
        .RF_DEPTH     (16),
        .TXQ_DEPTH    (4)
    ) dut (
        .REF_CLK (REF_CLK),
        .RST     (RST),
        .RX_IN   (RX_IN),
        .TX_OUT  (TX_OUT)
    );

    int checkCount  = 0;
    int passCount   = 0;
    int failCount   = 0;
    int frameCount  = 0;
    int pushedCount = 0;

    // Each entry: {parity enable, parity odd, byte}
    logic [9:0] expectQ[$];

    bit cfgParEn      = 1'b1;
    bit cfgParOdd     = 1'b0;
    bit monitorEnable = 1'b0;
    bit monitorBusy   = 1'b0;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Serialises one byte onto RX_IN using the parity setting the bench
    // believes the DUT currently holds, with optional corruption.
    task automatic applyStimulus(input logic [7:0] data, input bit badParity = 1'b0,
                                 input bit badStop = 1'b0);
        logic par;
        par = cfgParOdd ? ~^data : ^data;
        if (badParity) par = ~par;
        @(negedge REF_CLK);
        RX_IN = 1'b0;
        repeat (CPB) @(negedge REF_CLK);
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (CPB) @(negedge REF_CLK);
        end
        if (cfgParEn) begin
            RX_IN = par;
            repeat (CPB) @(negedge REF_CLK);
        end
        RX_IN = ~badStop;
        repeat (CPB) @(negedge REF_CLK);
        RX_IN = 1'b1;
        repeat (CPB) @(negedge REF_CLK);
    endtask

    task automatic expectByte(input logic [7:0] data);
        expectQ.push_back({cfgParEn, cfgParOdd, data});
        pushedCount++;
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
        applyStimulus(8'hAA);
        applyStimulus(addr);
        applyStimulus(data);
        if (addr[3:0] == 4'd2) begin
            cfgParEn  = data[0];
            cfgParOdd = data[1];
        end
    endtask

    task automatic readReg(input logic [7:0] addr, input logic [7:0] expected);
        expectByte(expected);
        applyStimulus(8'hBB);
        applyStimulus(addr);
    endtask

    task automatic aluCmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] fun, input logic [15:0] expected);
        expectByte(expected[7:0]);
        expectByte(expected[15:8]);
        applyStimulus(8'hCC);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(fun);
    endtask

    task automatic funCmd(input logic [7:0] fun, input logic [15:0] expected);
        expectByte(expected[7:0]);
        expectByte(expected[15:8]);
        applyStimulus(8'hDD);
        applyStimulus(fun);
    endtask

    // Waits (bounded) until every queued reply has been fully received.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((expectQ.size() != 0 || monitorBusy) && n < 4000) begin
            @(negedge REF_CLK);
            n++;
        end
        if (n >= 4000) checkOutput("drain_timeout_pending", 16'(expectQ.size()), 16'd0);
        repeat (4 * CPB) @(negedge REF_CLK);
    endtask

    // Frame decoder: samples each bit near its middle on falling clock edges.
    initial begin
        logic [7:0] got;
        logic [9:0] exp;
        forever begin
            @(negedge TX_OUT);
            if (!monitorEnable) continue;
            monitorBusy = 1'b1;
            repeat (CPB / 2) @(negedge REF_CLK);
            checkOutput("tx_start_bit", {15'd0, TX_OUT}, 16'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge REF_CLK);
                got[i] = TX_OUT;
            end
            if (expectQ.size() == 0) begin
                checkOutput("tx_unexpected_frame", {8'h00, got}, 16'h0100);
                exp = {cfgParEn, cfgParOdd, got};
            end else begin
                exp = expectQ.pop_front();
            end
            checkOutput($sformatf("tx_byte_%0d", frameCount), {8'h00, got}, {8'h00, exp[7:0]});
            if (exp[9]) begin
                repeat (CPB) @(negedge REF_CLK);
                checkOutput($sformatf("tx_parity_%0d", frameCount), {15'd0, TX_OUT},
                            {15'd0, (exp[8] ? ~^exp[7:0] : ^exp[7:0])});
            end
            repeat (CPB) @(negedge REF_CLK);
            checkOutput($sformatf("tx_stop_%0d", frameCount), {15'd0, TX_OUT}, 16'd1);
            frameCount++;
            monitorBusy = 1'b0;
        end
    end

    initial begin
        repeat (200000) @(posedge REF_CLK);
        $display("[TB] FAIL watchdog: simulation still running after 200000 cycles, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST   = 1'b1;
        RX_IN = 1'b1;
        #2 RST = 1'b0;
        repeat (5) @(negedge REF_CLK);
        checkOutput("reset_tx_idle", {15'd0, TX_OUT}, 16'd1);
        RST = 1'b1;
        repeat (5) @(negedge REF_CLK);
        monitorEnable = 1'b1;

        // Reset values
        readReg(8'h02, 8'h01);
        readReg(8'h00, 8'h00);
        waitDrain();

        // Write then read back
        writeReg(8'h06, 8'h28);
        readReg(8'h06, 8'h28);
        waitDrain();

        // Full ALU command and operand registers
        aluCmd(8'h07, 8'h02, 8'h00, 16'h0009);
        waitDrain();
        readReg(8'h00, 8'h07);
        readReg(8'h01, 8'h02);
        waitDrain();

        // Function-only commands on A=7, B=2
        funCmd(8'h01, 16'h0005);
        funCmd(8'h02, 16'h000E);
        funCmd(8'h03, 16'h0003);
        funCmd(8'h06, 16'h00FD);
        funCmd(8'h0B, 16'h0002);
        funCmd(8'h0E, 16'h000E);
        funCmd(8'h0F, 16'h0001);
        waitDrain();

        // Boundary operands
        aluCmd(8'hFF, 8'hFF, 8'h02, 16'hFE01);
        aluCmd(8'h05, 8'h00, 8'h03, 16'h0000);
        aluCmd(8'h05, 8'h05, 8'h0A, 16'h0001);
        aluCmd(8'h10, 8'h30, 8'h01, 16'hFFE0);
        aluCmd(8'h30, 8'h10, 8'h0C, 16'h0000);
        waitDrain();

        // Corrupted and ignored bytes must not advance the command FSM
        applyStimulus(8'hAA, 1'b1, 1'b0);
        readReg(8'h06, 8'h28);
        waitDrain();
        applyStimulus(8'hAA, 1'b0, 1'b1);
        readReg(8'h06, 8'h28);
        waitDrain();
        applyStimulus(8'h55);
        readReg(8'h06, 8'h28);
        waitDrain();

        // Short low glitch on RX_IN is rejected at mid-bit
        @(negedge REF_CLK);
        RX_IN = 1'b0;
        repeat (3) @(negedge REF_CLK);
        RX_IN = 1'b1;
        repeat (2 * CPB) @(negedge REF_CLK);
        readReg(8'h16, 8'h28);
        waitDrain();

        // Odd parity, then parity disabled
        writeReg(8'h02, 8'h03);
        readReg(8'h06, 8'h28);
        waitDrain();
        writeReg(8'h02, 8'h00);
        readReg(8'h06, 8'h28);
        waitDrain();

        // Reset in the middle of a received frame
        applyStimulus(8'hAA);
        applyStimulus(8'h06);
        @(negedge REF_CLK);
        RX_IN = 1'b0;
        repeat (3 * CPB) @(negedge REF_CLK);
        RST   = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge REF_CLK);
        checkOutput("reset_mid_frame_tx", {15'd0, TX_OUT}, 16'd1);
        RST = 1'b1;
        cfgParEn  = 1'b1;
        cfgParOdd = 1'b0;
        repeat (2 * CPB) @(negedge REF_CLK);
        readReg(8'h06, 8'h00);
        readReg(8'h02, 8'h01);
        waitDrain();

        checkOutput("frame_count", 16'(frameCount), 16'(pushedCount));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
